// File: rtl/mem_arbiter2.sv
// Two-master arbiter for a picorv32 native memory port.
// Round-robin or fixed-priority grant, with a watchdog that terminates stalled transfers.
module mem_arbiter2 #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    output logic        m0_mem_ready,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    output logic        m1_mem_ready,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic [31:0] m1_mem_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned    WdW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdW-1:0] WdLast = (TIMEOUT > 0) ? WdW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;   // 1 = master 1 owned the last completed transfer
    logic [WdW-1:0] wd_q, wd_d;
    logic           own_valid;
    logic           done;
    logic           tmo;
    logic           complete;
    logic [31:0]    rdata_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wd_d      = wd_q;
        done      = 1'b0;
        tmo       = 1'b0;
        own_valid = (state_q == StGnt1) ? m1_mem_valid : m0_mem_valid;
        case (state_q)
            StIdle: begin
                wd_d = '0;
                if (m0_mem_valid && m1_mem_valid) begin
                    state_d = (ROUND_ROBIN && !last_q) ? StGnt1 : StGnt0;
                end else if (m0_mem_valid) begin
                    state_d = StGnt0;
                end else if (m1_mem_valid) begin
                    state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                if (!own_valid) begin
                    // Master abandoned the request: release without touching fairness state.
                    state_d = StIdle;
                    wd_d    = '0;
                end else if (mem_ready) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    last_d  = (state_q == StGnt1);
                    wd_d    = '0;
                end else if (TIMEOUT != 0 && wd_q == WdLast) begin
                    tmo     = 1'b1;
                    state_d = StIdle;
                    last_d  = (state_q == StGnt1);
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign complete  = done | tmo;
    assign rdata_sel = tmo ? 32'hFFFF_FFFF : mem_rdata;

    always_comb begin
        mem_valid    = 1'b0;
        mem_instr    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        grant        = 2'b00;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        timeout_err  = tmo;
        case (state_q)
            StGnt0: begin
                mem_valid    = m0_mem_valid;
                mem_instr    = m0_mem_instr;
                mem_addr     = m0_mem_addr;
                mem_wdata    = m0_mem_wdata;
                mem_wstrb    = m0_mem_wstrb;
                grant        = 2'b01;
                m0_mem_ready = complete;
                m0_mem_rdata = complete ? rdata_sel : '0;
            end
            StGnt1: begin
                mem_valid    = m1_mem_valid;
                mem_instr    = m1_mem_instr;
                mem_addr     = m1_mem_addr;
                mem_wdata    = m1_mem_wdata;
                mem_wstrb    = m1_mem_wstrb;
                grant        = 2'b10;
                m1_mem_ready = complete;
                m1_mem_rdata = complete ? rdata_sel : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: instance 0 is round-robin, instance 1 fixed priority, both TIMEOUT=8.
// A transaction-level model predicts every output of both instances each cycle.
module tb_mem_arbiter2;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Master-side inputs indexed [dut][master]
    logic        v   [2][2];
    logic        ins [2][2];
    logic [31:0] adr [2][2];
    logic [31:0] wd  [2][2];
    logic [3:0]  ws  [2][2];
    logic        rdy [2][2];
    logic [31:0] rd  [2][2];
    // Shared-port signals indexed [dut]
    logic        mvld [2];
    logic        mins [2];
    logic        mrdy [2];
    logic [31:0] maddr[2];
    logic [31:0] mwd  [2];
    logic [3:0]  mws  [2];
    logic [31:0] mrd  [2];
    logic [1:0]  gnt  [2];
    logic        terr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter2 #(
            .ROUND_ROBIN(g == 0),
            .TIMEOUT    (TO)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .m0_mem_valid(v[g][0]),
            .m0_mem_instr(ins[g][0]),
            .m0_mem_ready(rdy[g][0]),
            .m0_mem_addr (adr[g][0]),
            .m0_mem_wdata(wd[g][0]),
            .m0_mem_wstrb(ws[g][0]),
            .m0_mem_rdata(rd[g][0]),
            .m1_mem_valid(v[g][1]),
            .m1_mem_instr(ins[g][1]),
            .m1_mem_ready(rdy[g][1]),
            .m1_mem_addr (adr[g][1]),
            .m1_mem_wdata(wd[g][1]),
            .m1_mem_wstrb(ws[g][1]),
            .m1_mem_rdata(rd[g][1]),
            .mem_valid   (mvld[g]),
            .mem_instr   (mins[g]),
            .mem_ready   (mrdy[g]),
            .mem_addr    (maddr[g]),
            .mem_wdata   (mwd[g]),
            .mem_wstrb   (mws[g]),
            .mem_rdata   (mrd[g]),
            .grant       (gnt[g]),
            .timeout_err (terr[g])
        );
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string tname = "init";

    // Reference model: owner (-1 = nobody), last completed owner, cycles waited in grant
    int own[2];
    int lst[2];
    int wt [2];

    // Values observed at the most recent tick
    logic [1:0]  ob_gnt [2];
    logic        ob_mv  [2];
    logic        ob_err [2];
    logic [31:0] ob_addr[2];
    logic [31:0] ob_wd  [2];
    logic [3:0]  ob_ws  [2];
    logic        ob_rdy [2][2];
    logic [31:0] ob_rd  [2][2];

    logic [1:0] gq0[$];
    logic [1:0] gq1[$];

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                v[d][m] = 1'b0; ins[d][m] = 1'b0; adr[d][m] = '0; wd[d][m] = '0; ws[d][m] = '0;
            end
            mrdy[d] = 1'b0;
            mrd[d]  = '0;
        end
    endtask

    // Check both instances against the model for the current cycle, then advance one cycle.
    task automatic tick();
        logic [138:0] e, o;
        logic [1:0]   eg;
        logic         ev, ei, er0, er1, eerr;
        logic [31:0]  ea, ew, erd0, erd1;
        logic [3:0]   es;
        int           m;
        bit           fin, to;
        #1;
        for (int d = 0; d < 2; d++) begin
            eg = '0; ev = 0; ei = 0; ea = '0; ew = '0; es = '0;
            er0 = 0; er1 = 0; erd0 = '0; erd1 = '0; eerr = 0; fin = 0; to = 0;
            if (!rst && own[d] >= 0) begin
                m  = own[d];
                eg = (m == 0) ? 2'b01 : 2'b10;
                ev = v[d][m]; ei = ins[d][m]; ea = adr[d][m]; ew = wd[d][m]; es = ws[d][m];
                if (v[d][m]) begin
                    if (mrdy[d]) fin = 1;
                    else if (wt[d] + 1 == TO) begin fin = 1; to = 1; end
                end
                if (fin && m == 0) begin er0 = 1; erd0 = to ? 32'hFFFF_FFFF : mrd[d]; end
                if (fin && m == 1) begin er1 = 1; erd1 = to ? 32'hFFFF_FFFF : mrd[d]; end
                eerr = to;
            end
            e = {eg, ev, ei, ea, ew, es, er0, erd0, er1, erd1, eerr};
            o = {gnt[d], mvld[d], mins[d], maddr[d], mwd[d], mws[d],
                 rdy[d][0], rd[d][0], rdy[d][1], rd[d][1], terr[d]};
            ob_gnt[d] = gnt[d]; ob_mv[d] = mvld[d]; ob_err[d] = terr[d];
            ob_addr[d] = maddr[d]; ob_wd[d] = mwd[d]; ob_ws[d] = mws[d];
            for (int k = 0; k < 2; k++) begin ob_rdy[d][k] = rdy[d][k]; ob_rd[d][k] = rd[d][k]; end
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d outputs: got %h expected %h", tname, d, cyc, o, e);
            end
            if (rst) begin
                own[d] = -1; lst[d] = 1; wt[d] = 0;
            end else if (own[d] < 0) begin
                wt[d] = 0;
                if (v[d][0] && v[d][1]) own[d] = (d == 0) ? 1 - lst[d] : 0;
                else if (v[d][0]) own[d] = 0;
                else if (v[d][1]) own[d] = 1;
            end else if (!v[d][own[d]]) begin
                own[d] = -1;
            end else if (fin) begin
                lst[d] = own[d];
                own[d] = -1;
            end else begin
                wt[d]++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tname = "reset";
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b00 || ob_mv[0] !== 1'b0 || ob_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state grant/valid/err got %b/%b/%b expected 00/0/0",
                     ob_gnt[0], ob_mv[0], ob_err[0]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b00) begin
            errors++; $display("FAIL reset_idle grant got %b expected 00", ob_gnt[0]);
        end
    endtask

    task automatic test_single_read();
        tname = "single_read";
        do_reset();
        v[0][0] = 1'b1; adr[0][0] = 32'h100;
        tick();
        checks++;
        if (ob_mv[0] !== 1'b0 || ob_gnt[0] !== 2'b00) begin
            errors++; $display("FAIL read_latency valid/grant got %b/%b expected 0/00", ob_mv[0], ob_gnt[0]);
        end
        tick();
        checks++;
        if (ob_mv[0] !== 1'b1 || ob_gnt[0] !== 2'b01 || ob_addr[0] !== 32'h100) begin
            errors++;
            $display("FAIL read_grant valid/grant/addr got %b/%b/%h expected 1/01/00000100",
                     ob_mv[0], ob_gnt[0], ob_addr[0]);
        end
        tick();
        mrdy[0] = 1'b1; mrd[0] = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (ob_rdy[0][0] !== 1'b1 || ob_rd[0][0] !== 32'hDEAD_BEEF || ob_rdy[0][1] !== 1'b0) begin
            errors++;
            $display("FAIL read_data m0rdy/rdata/m1rdy got %b/%h/%b expected 1/deadbeef/0",
                     ob_rdy[0][0], ob_rd[0][0], ob_rdy[0][1]);
        end
        v[0][0] = 1'b0; mrdy[0] = 1'b0; mrd[0] = '0;
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b00) begin
            errors++; $display("FAIL read_release grant got %b expected 00", ob_gnt[0]);
        end
    endtask

    task automatic test_round_robin();
        int         comp0, comp1, m1c;
        logic [1:0] exp, got;
        tname = "round_robin";
        do_reset();
        gq0.delete(); gq1.delete();
        comp0 = 0; comp1 = 0; m1c = 0;
        for (int d = 0; d < 2; d++) begin
            v[d][0] = 1'b1; v[d][1] = 1'b1; mrdy[d] = 1'b1;
            adr[d][0] = 32'hA0; adr[d][1] = 32'hB0;
        end
        for (int i = 0; i < 8; i++) begin
            mrd[0] = $urandom; mrd[1] = $urandom;
            tick();
            if (ob_gnt[0] !== 2'b00) gq0.push_back(ob_gnt[0]);
            if (ob_gnt[1] !== 2'b00) gq1.push_back(ob_gnt[1]);
            comp0 += int'(ob_rdy[0][0]) + int'(ob_rdy[0][1]);
            comp1 += int'(ob_rdy[1][0]) + int'(ob_rdy[1][1]);
            m1c   += int'(ob_rdy[1][1]);
        end
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            got = (i < gq0.size()) ? gq0[i] : 2'bxx;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rr_order slot %0d grant got %b expected %b", i, got, exp);
            end
            got = (i < gq1.size()) ? gq1[i] : 2'bxx;
            checks++;
            if (got !== 2'b01) begin
                errors++; $display("FAIL fixed_order slot %0d grant got %b expected 01", i, got);
            end
        end
        checks++;
        if (comp0 != 4 || comp1 != 4 || m1c != 0) begin
            errors++;
            $display("FAIL rr_count completions rr/fixed/m1fixed got %0d/%0d/%0d expected 4/4/0",
                     comp0, comp1, m1c);
        end
    endtask

    task automatic test_write_m1();
        tname = "write_m1";
        do_reset();
        v[0][1] = 1'b1; adr[0][1] = 32'h2000; wd[0][1] = 32'h1234_5678; ws[0][1] = 4'hF;
        tick();
        tick();
        checks++;
        if (ob_addr[0] !== 32'h2000 || ob_wd[0] !== 32'h1234_5678 || ob_ws[0] !== 4'hF ||
            ob_gnt[0] !== 2'b10) begin
            errors++;
            $display("FAIL write_fields addr/wdata/wstrb/grant got %h/%h/%h/%b expected 00002000/12345678/f/10",
                     ob_addr[0], ob_wd[0], ob_ws[0], ob_gnt[0]);
        end
        mrdy[0] = 1'b1;
        tick();
        checks++;
        if (ob_rdy[0][1] !== 1'b1 || ob_rdy[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL write_ready m1rdy/m0rdy got %b/%b expected 1/0", ob_rdy[0][1], ob_rdy[0][0]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int early;
        tname = "timeout";
        do_reset();
        v[0][0] = 1'b1; adr[0][0] = 32'h40;
        tick();
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) early += int'(ob_err[0]) + int'(ob_rdy[0][0]);
        end
        checks++;
        if (early != 0 || ob_rdy[0][0] !== 1'b1 || ob_rd[0][0] !== 32'hFFFF_FFFF || ob_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire early/rdy/rdata/err got %0d/%b/%h/%b expected 0/1/ffffffff/1",
                     early, ob_rdy[0][0], ob_rd[0][0], ob_err[0]);
        end
        v[0][0] = 1'b0;
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b00 || ob_err[0] !== 1'b0) begin
            errors++; $display("FAIL timeout_idle grant/err got %b/%b expected 00/0", ob_gnt[0], ob_err[0]);
        end
        v[0][0] = 1'b1;
        tick();
        for (int i = 1; i < 8; i++) tick();
        mrdy[0] = 1'b1; mrd[0] = 32'hCAFE_F00D;
        tick();
        checks++;
        if (ob_rdy[0][0] !== 1'b1 || ob_rd[0][0] !== 32'hCAFE_F00D || ob_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_race rdy/rdata/err got %b/%h/%b expected 1/cafef00d/0",
                     ob_rdy[0][0], ob_rd[0][0], ob_err[0]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid";
        do_reset();
        v[0][1] = 1'b1; adr[0][1] = 32'h3000; wd[0][1] = 32'h55; ws[0][1] = 4'h3;
        tick();
        #1;
        checks++;
        if (mvld[0] !== 1'b1 || gnt[0] !== 2'b10) begin
            errors++; $display("FAIL midreset_pre valid/grant got %b/%b expected 1/10", mvld[0], gnt[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mvld[0] !== 1'b0 || gnt[0] !== 2'b00 || maddr[0] !== 32'h0 || mwd[0] !== 32'h0 ||
            mws[0] !== 4'h0 || rdy[0][1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async valid/grant/addr/wdata/wstrb/rdy got %b/%b/%h/%h/%h/%b expected all 0",
                     mvld[0], gnt[0], maddr[0], mwd[0], mws[0], rdy[0][1]);
        end
        tick();
        rst = 1'b0;
        v[0][0] = 1'b1;
        tick();
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b01) begin
            errors++; $display("FAIL midreset_first grant got %b expected 01", ob_gnt[0]);
        end
    endtask

    task automatic test_abort();
        tname = "abort";
        do_reset();
        v[0][0] = 1'b1;
        tick();
        tick();
        tick();
        v[0][0] = 1'b0;
        tick();
        checks++;
        if (ob_rdy[0][0] !== 1'b0 || ob_err[0] !== 1'b0) begin
            errors++; $display("FAIL abort_noready rdy/err got %b/%b expected 0/0", ob_rdy[0][0], ob_err[0]);
        end
        v[0][0] = 1'b1; v[0][1] = 1'b1;
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b00) begin
            errors++; $display("FAIL abort_idle grant got %b expected 00", ob_gnt[0]);
        end
        tick();
        checks++;
        if (ob_gnt[0] !== 2'b01) begin
            errors++; $display("FAIL abort_tie grant got %b expected 01", ob_gnt[0]);
        end
    endtask

    task automatic test_random();
        tname = "random";
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    if (v[d][m] && ob_rdy[d][m]) v[d][m] = 1'($urandom % 2);
                    else if (v[d][m] && ($urandom % 50 == 0)) v[d][m] = 1'b0;
                    else if (!v[d][m] && ($urandom % 3 == 0)) v[d][m] = 1'b1;
                    if (v[d][m] && (!ob_rdy[d][m] || !v[d][m]) && 1'b0) v[d][m] = 1'b0;
                end
            end
            // New request fields only on a fresh request; held fields otherwise
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    if (v[d][m] && (ob_rdy[d][m] || own[d] != m)) begin
                        if (own[d] != m || ob_rdy[d][m]) begin
                            adr[d][m] = $urandom; wd[d][m] = $urandom;
                            ws[d][m] = 4'($urandom); ins[d][m] = 1'($urandom);
                        end
                    end
                end
                mrdy[d] = (i < 400) ? 1'($urandom % 2) : ($urandom % 12 == 0);
                mrd[d]  = $urandom;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int d = 0; d < 2; d++) begin own[d] = -1; lst[d] = 1; wt[d] = 0; end
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin ob_rdy[d][k] = 1'b0; ob_rd[d][k] = '0; end
        end
        @(negedge clk);
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_m1();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
